// File: rtl/usb_comms_pkg.sv
// Shared types and register map for the USB status-line conditioner.
// Holds the debounce FSM state encoding and the Avalon-MM word addresses.
package usb_comms_pkg;

  typedef enum logic [1:0] {
    StStableLo = 2'd0,
    StQualHi   = 2'd1,
    StStableHi = 2'd2,
    StQualLo   = 2'd3
  } line_state_e;

  localparam logic [1:0] ADDR_STATUS   = 2'd0;
  localparam logic [1:0] ADDR_GLITCH   = 2'd1;
  localparam logic [1:0] ADDR_DEBOUNCE = 2'd2;

  // Wide enough for the largest legal DEBOUNCE_CYCLES (65535).
  localparam int unsigned QUAL_W = 16;

  function automatic line_state_e stable_state(input logic level);
    return level ? StStableHi : StStableLo;
  endfunction

endpackage

// File: rtl/usb_line_conditioner_if.sv
// Avalon-MM slave bus bundle for the USB line conditioner register block.
interface usb_line_conditioner_if;

  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );

endinterface

// File: rtl/usb_line_conditioner_sync2.sv
// Two-flop synchroniser for the raw asynchronous USB status pin.
module usb_sync2 #(
  parameter bit RESET_LEVEL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= RESET_LEVEL;
      sync_q <= RESET_LEVEL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/usb_line_conditioner.sv
// Debounces a USB status pin, emits edge strobes and exposes status over Avalon-MM.
// Define USB_LINE_GLITCH_CNT_EN to build the saturating glitch counter.
module usb_line_conditioner
  import usb_comms_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000,
  parameter bit          RESET_LEVEL     = 1'b1,
  parameter int unsigned CNT_W           = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   line_in,
  output logic                   line_out,
  output logic                   rise_pulse,
  output logic                   fall_pulse,
  usb_line_conditioner_if.slave  bus
);

  localparam logic [QUAL_W-1:0] QualLast = QUAL_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [QUAL_W-1:0] QualOne  = QUAL_W'(1);

  logic sync_q;

  usb_sync2 #(
    .RESET_LEVEL (RESET_LEVEL)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (line_in),
    .q     (sync_q)
  );

  line_state_e       state_q, state_d;
  logic [QUAL_W-1:0] qual_q, qual_d;
  logic              line_q, line_d;
  logic              rise_q, rise_d;
  logic              fall_q, fall_d;
  logic [31:0]       readdata_q, readdata_d;
  logic              glitch_ev;
  logic              glitch_clr;
  logic [CNT_W-1:0]  glitch_cnt;

  // A mismatch during qualification is checked before completion, so a
  // level that flips on the final count is still a glitch.
  always_comb begin
    state_d   = state_q;
    qual_d    = qual_q;
    line_d    = line_q;
    rise_d    = 1'b0;
    fall_d    = 1'b0;
    glitch_ev = 1'b0;
    unique case (state_q)
      StStableLo: begin
        if (sync_q) begin
          state_d = StQualHi;
          qual_d  = QualOne;
        end
      end
      StStableHi: begin
        if (!sync_q) begin
          state_d = StQualLo;
          qual_d  = QualOne;
        end
      end
      StQualHi: begin
        if (!sync_q) begin
          state_d   = StStableLo;
          qual_d    = '0;
          glitch_ev = 1'b1;
        end else if (qual_q == QualLast) begin
          state_d = StStableHi;
          qual_d  = '0;
          line_d  = 1'b1;
          rise_d  = 1'b1;
        end else begin
          qual_d = qual_q + QualOne;
        end
      end
      StQualLo: begin
        if (sync_q) begin
          state_d   = StStableHi;
          qual_d    = '0;
          glitch_ev = 1'b1;
        end else if (qual_q == QualLast) begin
          state_d = StStableLo;
          qual_d  = '0;
          line_d  = 1'b0;
          fall_d  = 1'b1;
        end else begin
          qual_d = qual_q + QualOne;
        end
      end
      default: begin
        state_d = stable_state(RESET_LEVEL);
        qual_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= stable_state(RESET_LEVEL);
      qual_q  <= '0;
      line_q  <= RESET_LEVEL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      qual_q  <= qual_d;
      line_q  <= line_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign line_out   = line_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;

  assign glitch_clr = bus.chipselect && !bus.write_n && (bus.address == ADDR_GLITCH);

`ifdef USB_LINE_GLITCH_CNT_EN
  logic [CNT_W-1:0] glitch_q, glitch_d;

  // Clear has priority over a coincident glitch; count saturates at all-ones.
  always_comb begin
    glitch_d = glitch_q;
    if (glitch_clr) begin
      glitch_d = '0;
    end else if (glitch_ev && (glitch_q != '1)) begin
      glitch_d = glitch_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      glitch_q <= '0;
    end else begin
      glitch_q <= glitch_d;
    end
  end

  assign glitch_cnt = glitch_q;
`else
  logic unused_glitch;
  assign unused_glitch = glitch_ev ^ glitch_clr;
  assign glitch_cnt    = '0;
`endif

  // Write data carries no meaning; the write itself is the command.
  logic unused_wdata;
  assign unused_wdata = ^bus.writedata;

  always_comb begin
    readdata_d = '0;
    case (bus.address)
      ADDR_STATUS:   readdata_d = {30'b0, sync_q, line_q};
      ADDR_GLITCH:   readdata_d = 32'(glitch_cnt);
      ADDR_DEBOUNCE: readdata_d = 32'(DEBOUNCE_CYCLES);
      default:       readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata_q <= '0;
    end else begin
      readdata_q <= readdata_d;
    end
  end

  assign bus.readdata = readdata_q;

endmodule

// File: tb/tb_usb_line_conditioner.sv
// Self-checking bench for usb_line_conditioner (DEBOUNCE_CYCLES=4, RESET_LEVEL=1, CNT_W=4).
module tb_usb_line_conditioner;
  import usb_comms_pkg::*;

  localparam int unsigned Deb  = 4;
  localparam int unsigned CntW = 4;
`ifdef USB_LINE_GLITCH_CNT_EN
  localparam bit GlitchEn = 1'b1;
`else
  localparam bit GlitchEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic line_in;
  logic line_out;
  logic rise_pulse;
  logic fall_pulse;

  usb_line_conditioner_if bus ();

  usb_line_conditioner #(
    .DEBOUNCE_CYCLES (Deb),
    .RESET_LEVEL     (1'b1),
    .CNT_W           (CntW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .line_in    (line_in),
    .line_out   (line_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] exp;
    string       name;
  } vec_t;

  typedef struct {
    logic [31:0] exp;
    string       name;
  } sb_t;

  sb_t sb_q[$];
  vec_t vecs[8];

  int checks = 0;
  int errors = 0;
  int rise_cnt = 0;
  int fall_cnt = 0;
  int both_cnt = 0;
  int exp_glitch = 0;

  always @(negedge clk) begin
    if (!reset) begin
      if (rise_pulse) rise_cnt++;
      if (fall_pulse) fall_cnt++;
      if (rise_pulse && fall_pulse) both_cnt++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_cycle(input logic wr, input logic [1:0] addr, input logic [31:0] exp,
                           input string name);
    sb_t e;
    bus.chipselect = wr;
    bus.write_n    = !wr;
    bus.address    = addr;
    bus.writedata  = $urandom;
    e.exp  = exp;
    e.name = name;
    sb_q.push_back(e);
    tick();
    e = sb_q.pop_front();
    check(e.name, bus.readdata, e.exp);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic bump_glitch();
    if (GlitchEn) exp_glitch = (exp_glitch == 15) ? 15 : exp_glitch + 1;
  endtask

  task automatic glitch_pulse();
    line_in = 1'b0;
    tick();
    line_in = 1'b1;
    repeat (5) tick();
    bump_glitch();
  endtask

  // Counts edges from the first sampling edge (inclusive) until line_out shows lvl.
  task automatic wait_level(input logic lvl, output int n);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (line_out === lvl) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int f0;
    int r0;

    vecs[0] = '{1'b0, ADDR_STATUS,   32'h3,      "rd_status"};
    vecs[1] = '{1'b0, ADDR_GLITCH,   32'h0,      "rd_glitch"};
    vecs[2] = '{1'b0, ADDR_DEBOUNCE, 32'(Deb),   "rd_debounce"};
    vecs[3] = '{1'b0, 2'd3,          32'h0,      "rd_addr3"};
    vecs[4] = '{1'b1, ADDR_STATUS,   32'h3,      "wr_status_ignored"};
    vecs[5] = '{1'b1, ADDR_DEBOUNCE, 32'(Deb),   "wr_debounce_ignored"};
    vecs[6] = '{1'b1, 2'd3,          32'h0,      "wr_addr3_ignored"};
    vecs[7] = '{1'b0, ADDR_GLITCH,   32'h0,      "rd_glitch_after_wr"};

    reset          = 1'b1;
    line_in        = 1'b1;
    bus.address    = 2'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;

    repeat (3) tick();
    check("rst_line_out", 32'(line_out), 32'h1);
    check("rst_rise", 32'(rise_pulse), 32'h0);
    check("rst_fall", 32'(fall_pulse), 32'h0);
    check("rst_readdata", bus.readdata, 32'h0);
    reset = 1'b0;
    repeat (3) tick();
    check("release_no_pulse", 32'(rise_cnt + fall_cnt), 32'h0);

    for (int i = 0; i < 8; i++) begin
      bus_cycle(vecs[i].wr, vecs[i].addr, vecs[i].exp, vecs[i].name);
    end

    // Clean fall then clean rise.
    f0 = fall_cnt;
    r0 = rise_cnt;
    line_in = 1'b0;
    wait_level(1'b0, n);
    check("fall_latency", 32'(n), 32'(Deb + 2));
    check("fall_pulse_on", 32'(fall_pulse), 32'h1);
    check("fall_no_rise", 32'(rise_pulse), 32'h0);
    tick();
    check("fall_pulse_off", 32'(fall_pulse), 32'h0);
    bus_cycle(1'b0, ADDR_STATUS, 32'h0, "rd_status_low");
    bus_cycle(1'b0, ADDR_GLITCH, 32'(exp_glitch), "rd_glitch_clean_fall");
    check("fall_pulse_count", 32'(fall_cnt - f0), 32'h1);

    line_in = 1'b1;
    wait_level(1'b1, n);
    check("rise_latency", 32'(n), 32'(Deb + 2));
    check("rise_pulse_on", 32'(rise_pulse), 32'h1);
    tick();
    check("rise_pulse_off", 32'(rise_pulse), 32'h0);
    bus_cycle(1'b0, ADDR_STATUS, 32'h3, "rd_status_high");
    check("rise_pulse_count", 32'(rise_cnt - r0), 32'h1);

    // Low for three samples is one cycle short of qualifying.
    f0 = fall_cnt;
    r0 = rise_cnt;
    line_in = 1'b0;
    repeat (3) tick();
    line_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("short_low_line_out", 32'(line_out), 32'h1);
    end
    bump_glitch();
    check("short_low_no_pulse", 32'(fall_cnt - f0 + rise_cnt - r0), 32'h0);
    bus_cycle(1'b0, ADDR_GLITCH, 32'(exp_glitch), "rd_glitch_one");

    // Saturation of the 4-bit glitch counter, then clear.
    for (int i = 0; i < 20; i++) glitch_pulse();
    bus_cycle(1'b0, ADDR_GLITCH, 32'(exp_glitch), "rd_glitch_sat");
    bus_cycle(1'b1, ADDR_GLITCH, 32'(exp_glitch), "wr_glitch_cycle");
    exp_glitch = 0;
    bus_cycle(1'b0, ADDR_GLITCH, 32'h0, "rd_glitch_cleared");

    // Clear lands on the same edge that records a glitch.
    glitch_pulse();
    glitch_pulse();
    bus_cycle(1'b0, ADDR_GLITCH, 32'(exp_glitch), "rd_glitch_two");
    line_in = 1'b0;
    tick();
    line_in = 1'b1;
    tick();
    tick();
    bus_cycle(1'b1, ADDR_GLITCH, 32'(exp_glitch), "clr_vs_glitch_wr");
    exp_glitch = 0;
    repeat (3) tick();
    bus_cycle(1'b0, ADDR_GLITCH, 32'h0, "clr_wins");

    // Reset in the middle of qualifying a fall.
    f0 = fall_cnt;
    r0 = rise_cnt;
    line_in = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    #1;
    check("midqual_rst_line_out", 32'(line_out), 32'h1);
    check("midqual_rst_fall", 32'(fall_pulse), 32'h0);
    line_in = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    exp_glitch = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("post_rst_line_out", 32'(line_out), 32'h1);
    end
    check("post_rst_state", 32'(dut.state_q), 32'(StStableHi));
    check("post_rst_no_pulse", 32'(fall_cnt - f0 + rise_cnt - r0), 32'h0);
    bus_cycle(1'b0, ADDR_GLITCH, 32'h0, "post_rst_glitch");

    check("never_both_pulses", 32'(both_cnt), 32'h0);
    check("sb_empty", 32'(sb_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
